// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 VGA timing constants, counter type and sync-window helper.
// Overlay objects take their screen geometry from here as well.
package vga_timing_pkg;

    localparam int unsigned CNT_W     = 10;
    localparam int unsigned CNT_LIMIT = 1 << CNT_W;

    typedef logic [CNT_W-1:0] cnt_t;

    localparam int unsigned DEF_CLK_DIV   = 2;
    localparam int unsigned DEF_H_DISPLAY = 640;
    localparam int unsigned DEF_H_FRONT   = 16;
    localparam int unsigned DEF_H_SYNC    = 96;
    localparam int unsigned DEF_H_BACK    = 48;
    localparam int unsigned DEF_V_DISPLAY = 480;
    localparam int unsigned DEF_V_FRONT   = 10;
    localparam int unsigned DEF_V_SYNC    = 2;
    localparam int unsigned DEF_V_BACK    = 33;

    localparam int unsigned DEF_H_TOTAL =
        DEF_H_DISPLAY + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK;
    localparam int unsigned DEF_V_TOTAL =
        DEF_V_DISPLAY + DEF_V_FRONT + DEF_V_SYNC + DEF_V_BACK;

    localparam int unsigned DEF_H_SYNC_START = DEF_H_DISPLAY + DEF_H_FRONT;
    localparam int unsigned DEF_H_SYNC_END   = DEF_H_SYNC_START + DEF_H_SYNC - 1;
    localparam int unsigned DEF_V_SYNC_START = DEF_V_DISPLAY + DEF_V_FRONT;
    localparam int unsigned DEF_V_SYNC_END   = DEF_V_SYNC_START + DEF_V_SYNC - 1;

    function automatic logic in_window(input cnt_t val, input cnt_t lo, input cnt_t hi);
        return (val >= lo) && (val <= hi);
    endfunction

endpackage

// File: rtl/vga_pixel_tick.sv
// Modulo-CLK_DIV divider producing a one-clk pixel enable.
// With CLK_DIV=1 the divider stays at 0, so the enable is held high.
module vga_pixel_tick #(
    parameter int unsigned CLK_DIV = 2
) (
    input  logic i_clk,
    input  logic i_rst,
    output logic o_tick
);

    localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    generate
        if (CLK_DIV < 1) begin : g_div_check
            $error("vga_pixel_tick: CLK_DIV must be 1 or more");
        end
    endgenerate

    logic [DIV_W-1:0] r_div;

    assign o_tick = (r_div == DIV_LAST);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_div <= '0;
        end else if (o_tick) begin
            r_div <= '0;
        end else begin
            r_div <= r_div + 1'b1;
        end
    end

endmodule

// File: rtl/vga_sync_gen.sv
// VGA raster timing source: pixel enable, H/V counters, active-low syncs,
// visible-area flag and frame-start pulse.
module vga_sync_gen
    import vga_timing_pkg::*;
#(
    parameter int unsigned CLK_DIV   = DEF_CLK_DIV,
    parameter int unsigned H_DISPLAY = DEF_H_DISPLAY,
    parameter int unsigned H_FRONT   = DEF_H_FRONT,
    parameter int unsigned H_SYNC    = DEF_H_SYNC,
    parameter int unsigned H_BACK    = DEF_H_BACK,
    parameter int unsigned V_DISPLAY = DEF_V_DISPLAY,
    parameter int unsigned V_FRONT   = DEF_V_FRONT,
    parameter int unsigned V_SYNC    = DEF_V_SYNC,
    parameter int unsigned V_BACK    = DEF_V_BACK
) (
    input  logic       clk,
    input  logic       reset,
    output logic       p_tick,
    output logic [9:0] HCount,
    output logic [9:0] VCount,
    output logic       HSync,
    output logic       VSync,
    output logic       video_on,
    output logic       frame_start
);

    localparam int unsigned H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

    generate
        if (H_TOTAL > CNT_LIMIT) begin : g_h_check
            $error("vga_sync_gen: H_TOTAL exceeds 1024");
        end
        if (V_TOTAL > CNT_LIMIT) begin : g_v_check
            $error("vga_sync_gen: V_TOTAL exceeds 1024");
        end
        if (CLK_DIV < 1) begin : g_div_check
            $error("vga_sync_gen: CLK_DIV must be 1 or more");
        end
    endgenerate

    localparam cnt_t H_LAST     = cnt_t'(H_TOTAL - 1);
    localparam cnt_t V_LAST     = cnt_t'(V_TOTAL - 1);
    localparam cnt_t H_VIS      = cnt_t'(H_DISPLAY);
    localparam cnt_t V_VIS      = cnt_t'(V_DISPLAY);
    localparam cnt_t HS_START   = cnt_t'(H_DISPLAY + H_FRONT);
    localparam cnt_t HS_END     = cnt_t'(H_DISPLAY + H_FRONT + H_SYNC - 1);
    localparam cnt_t VS_START   = cnt_t'(V_DISPLAY + V_FRONT);
    localparam cnt_t VS_END     = cnt_t'(V_DISPLAY + V_FRONT + V_SYNC - 1);

    logic w_tick;
    logic w_h_last;
    logic w_v_last;
    cnt_t w_h_next;
    cnt_t w_v_next;
    cnt_t r_hcount;
    cnt_t r_vcount;
    logic r_hsync;
    logic r_vsync;

    vga_pixel_tick #(
        .CLK_DIV(CLK_DIV)
    ) u_pixel_tick (
        .i_clk (clk),
        .i_rst (reset),
        .o_tick(w_tick)
    );

    assign w_h_last = (r_hcount == H_LAST);
    assign w_v_last = (r_vcount == V_LAST);

    always_comb begin
        w_h_next = r_hcount;
        w_v_next = r_vcount;
        if (w_tick) begin
            if (w_h_last) begin
                w_h_next = '0;
                w_v_next = w_v_last ? '0 : r_vcount + cnt_t'(1);
            end else begin
                w_h_next = r_hcount + cnt_t'(1);
            end
        end
    end

    // Syncs decode the next counts so they line up with the counters without lag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hcount <= '0;
            r_vcount <= '0;
            r_hsync  <= 1'b1;
            r_vsync  <= 1'b1;
        end else begin
            r_hcount <= w_h_next;
            r_vcount <= w_v_next;
            r_hsync  <= ~in_window(w_h_next, HS_START, HS_END);
            r_vsync  <= ~in_window(w_v_next, VS_START, VS_END);
        end
    end

    assign p_tick      = w_tick;
    assign HCount      = r_hcount;
    assign VCount      = r_vcount;
    assign HSync       = r_hsync;
    assign VSync       = r_vsync;
    assign video_on    = (r_hcount < H_VIS) && (r_vcount < V_VIS);
    assign frame_start = w_tick && w_h_last && w_v_last;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Self-checking bench for vga_sync_gen: default 640x480 timing plus a shrunken
// raster (15x10) at CLK_DIV 1, 2 and 4 for frame-level and divider checks.
module tb_vga_sync_gen;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic       d_pt, d_hs, d_vs, d_von, d_fs;
    logic [9:0] d_h, d_v;
    logic       s_pt, s_hs, s_vs, s_von, s_fs;
    logic [9:0] s_h, s_v;
    logic       o_pt, o_hs, o_vs, o_von, o_fs;
    logic [9:0] o_h, o_v;
    logic       f_pt, f_hs, f_vs, f_von, f_fs;
    logic [9:0] f_h, f_v;

    vga_sync_gen u_def (
        .clk(clk), .reset(reset), .p_tick(d_pt), .HCount(d_h), .VCount(d_v),
        .HSync(d_hs), .VSync(d_vs), .video_on(d_von), .frame_start(d_fs)
    );

    vga_sync_gen #(
        .CLK_DIV(2), .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
        .V_DISPLAY(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(1)
    ) u_sm (
        .clk(clk), .reset(reset), .p_tick(s_pt), .HCount(s_h), .VCount(s_v),
        .HSync(s_hs), .VSync(s_vs), .video_on(s_von), .frame_start(s_fs)
    );

    vga_sync_gen #(
        .CLK_DIV(1), .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
        .V_DISPLAY(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(1)
    ) u_d1 (
        .clk(clk), .reset(reset), .p_tick(o_pt), .HCount(o_h), .VCount(o_v),
        .HSync(o_hs), .VSync(o_vs), .video_on(o_von), .frame_start(o_fs)
    );

    vga_sync_gen #(
        .CLK_DIV(4), .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
        .V_DISPLAY(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(1)
    ) u_d4 (
        .clk(clk), .reset(reset), .p_tick(f_pt), .HCount(f_h), .VCount(f_v),
        .HSync(f_hs), .VSync(f_vs), .video_on(f_von), .frame_start(f_fs)
    );

    // k = clk edges since reset release; flags = {HSync,VSync,video_on,p_tick,frame_start}
    typedef struct {
        string name;
        int    k;
        int    h;
        int    v;
        int    flags;
    } vec_t;

    vec_t tbl[12];
    int n_pass = 0;
    int n_total = 0;

    function automatic vec_t mk(input string name, input int k, input int h,
                                input int v, input int flags);
        vec_t r;
        r.name = name; r.k = k; r.h = h; r.v = v; r.flags = flags;
        return r;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    function automatic int dflags();
        return int'({d_hs, d_vs, d_von, d_pt, d_fs});
    endfunction

    function automatic int sflags();
        return int'({s_hs, s_vs, s_von, s_pt, s_fs});
    endfunction

    initial begin
        int k_now;
        int cnt;
        int first_low;
        int s_vis, s_vis_tk, s_hlo, s_vlo, s_hbad, s_vbad, s_fs_n, s_fs_a, s_fs_b;
        int o_pt_n, f_pt_n, f_first;

        tbl[0]  = mk("rst_state",   0,    0,   0, 5'b11100);
        tbl[1]  = mk("first_div",   1,    0,   0, 5'b11110);
        tbl[2]  = mk("first_tick",  2,    1,   0, 5'b11100);
        tbl[3]  = mk("second_div",  3,    1,   0, 5'b11110);
        tbl[4]  = mk("h639",        1278, 639, 0, 5'b11100);
        tbl[5]  = mk("h640_blank",  1280, 640, 0, 5'b11000);
        tbl[6]  = mk("hs_start",    1312, 656, 0, 5'b01000);
        tbl[7]  = mk("hs_last",     1503, 751, 0, 5'b01010);
        tbl[8]  = mk("hs_end",      1504, 752, 0, 5'b11000);
        tbl[9]  = mk("h799",        1598, 799, 0, 5'b11000);
        tbl[10] = mk("h799_tick",   1599, 799, 0, 5'b11010);
        tbl[11] = mk("line_wrap",   1600, 0,   1, 5'b11100);

        do_reset();
        k_now = 0;
        for (int i = 0; i < 12; i++) begin
            while (k_now < tbl[i].k) begin
                step();
                k_now++;
            end
            check({tbl[i].name, ".h"}, int'(d_h), tbl[i].h);
            check({tbl[i].name, ".v"}, int'(d_v), tbl[i].v);
            check({tbl[i].name, ".flags"}, dflags(), tbl[i].flags);
        end

        // One full line (line 1): HSync low 96 ticks = 192 clks, starting at 656.
        cnt = 0;
        first_low = -1;
        for (int i = 0; i < 1600; i++) begin
            step();
            if (!d_hs) begin
                cnt++;
                if (first_low < 0) first_low = int'(d_h);
            end
        end
        check("line_hs_low_clks", cnt, 192);
        check("line_hs_first_h", first_low, 656);
        check("line2_h", int'(d_h), 0);
        check("line2_v", int'(d_v), 2);

        // Reset while HSync is low at (700,2).
        cnt = 0;
        while (d_h != 10'd700 && cnt < 3000) begin
            step();
            cnt++;
        end
        check("wait_h700", int'(d_h == 10'd700), 1);
        check("h700_hs_low", int'(d_hs), 0);
        #2 reset = 1'b1;
        #1;
        check("async_rst_h", int'(d_h), 0);
        check("async_rst_v", int'(d_v), 0);
        check("async_rst_flags", dflags(), 5'b11100);
        @(posedge clk);
        #1;
        reset = 1'b0;
        step();
        check("resume_k1_flags", dflags(), 5'b11110);
        step();
        check("resume_k2_h", int'(d_h), 1);

        // Shrunken raster: 15x10, hsync h in [10,12], vsync v in [7,8], visible 8x6.
        do_reset();
        s_vis = 0; s_vis_tk = 0; s_hlo = 0; s_vlo = 0; s_hbad = 0; s_vbad = 0;
        s_fs_n = 0; s_fs_a = -1; s_fs_b = -1;
        o_pt_n = 0; f_pt_n = 0; f_first = -1;
        for (int k = 0; k < 600; k++) begin
            if (s_von) s_vis++;
            if (s_von && s_pt) s_vis_tk++;
            if (!s_hs) s_hlo++;
            if (!s_vs) s_vlo++;
            if ((!s_hs) != (s_h >= 10'd10 && s_h <= 10'd12)) s_hbad++;
            if ((!s_vs) != (s_v == 10'd7 || s_v == 10'd8)) s_vbad++;
            if (s_fs) begin
                s_fs_n++;
                if (s_fs_a < 0) s_fs_a = k;
                else if (s_fs_b < 0) s_fs_b = k;
            end
            if (k < 20 && o_pt) o_pt_n++;
            if (k < 40 && f_pt) begin
                f_pt_n++;
                if (f_first < 0) f_first = k;
            end
            if (k == 4) check("div4_k4_h", int'(f_h), 1);
            if (k == 20) begin
                check("div1_k20_h", int'(o_h), 5);
                check("div1_k20_v", int'(o_v), 1);
            end
            if (k == 165) begin
                check("sm_7_5_h", int'(s_h), 7);
                check("sm_7_5_flags", sflags(), 5'b11110);
            end
            if (k == 166) begin
                check("sm_8_5_h", int'(s_h), 8);
                check("sm_8_5_flags", sflags(), 5'b11000);
            end
            if (k == 299) begin
                check("sm_last_hv", int'({s_h, s_v}), int'({10'd14, 10'd9}));
                check("sm_last_flags", sflags(), 5'b11011);
            end
            if (k == 300) begin
                check("sm_wrap_hv", int'({s_h, s_v}), 0);
                check("sm_wrap_flags", sflags(), 5'b11100);
            end
            step();
        end
        check("sm_video_clks", s_vis, 192);
        check("sm_video_ticks", s_vis_tk, 96);
        check("sm_hs_low_clks", s_hlo, 120);
        check("sm_vs_low_clks", s_vlo, 120);
        check("sm_hs_window_errs", s_hbad, 0);
        check("sm_vs_window_errs", s_vbad, 0);
        check("sm_fs_count", s_fs_n, 2);
        check("sm_fs_first_k", s_fs_a, 299);
        check("sm_fs_period", s_fs_b - s_fs_a, 300);
        check("div1_pt_high", o_pt_n, 20);
        check("div4_pt_count", f_pt_n, 10);
        check("div4_pt_first", f_first, 3);

        // Mid-frame reset on the small raster at (11,3) with HSync low.
        cnt = 0;
        while (!(s_h == 10'd11 && s_v == 10'd3) && cnt < 400) begin
            step();
            cnt++;
        end
        check("wait_sm_11_3", int'(s_h == 10'd11 && s_v == 10'd3), 1);
        check("sm_11_3_hs", int'(s_hs), 0);
        #2 reset = 1'b1;
        #1;
        check("sm_async_rst_hv", int'({s_h, s_v}), 0);
        check("sm_async_rst_flags", sflags(), 5'b11100);
        @(posedge clk);
        #1;
        reset = 1'b0;
        step();
        step();
        check("sm_resume_h", int'(s_h), 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
